// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus-master driver: bus addresses, status bits,
// state encoding and the baud divisor helper.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam int STAT_RDA = 0;
  localparam int STAT_TBR = 1;

  typedef enum logic [2:0] {
    INIT_LOW,
    INIT_HIGH,
    POLL_RX,
    READ_RX,
    POLL_TX,
    WRITE_TX,
    GAP
  } drv_state_t;

  typedef struct packed {
    logic       rd;
    logic [1:0] addr;
  } bus_t;

  // Divisor = round(clk_hz / baud) - 1, with baud = 4800 * 2^sel.
  function automatic logic [15:0] baud_divisor(input int unsigned clk_hz, input logic [1:0] sel);
    int unsigned baud;
    baud = 32'd4800 << sel;
    return 16'((clk_hz + baud / 2) / baud - 1);
  endfunction

  function automatic bus_t bus_of(input drv_state_t s);
    case (s)
      INIT_LOW:  return '{rd: 1'b0, addr: ADDR_DBL};
      INIT_HIGH: return '{rd: 1'b0, addr: ADDR_DBH};
      READ_RX:   return '{rd: 1'b1, addr: ADDR_BUF};
      WRITE_TX:  return '{rd: 1'b0, addr: ADDR_BUF};
      default:   return '{rd: 1'b1, addr: ADDR_STAT};
    endcase
  endfunction

endpackage

// File: rtl/spart_driver_sync2.sv
// Two-flop synchronizer for slow asynchronous level inputs such as DIP switches.
module sync2 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so meta->q forms a real two-stage pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spart_driver.sv
// Bus master for the SPART control block: programs the baud divisor from br_cfg,
// then echoes every received byte back to the transmitter.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned POLL_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam logic [3:0]  GAP_LOAD = 4'(POLL_GAP - 1);
  localparam logic [15:0] DIV_TABLE [4] = '{
    baud_divisor(CLK_HZ, 2'd0), baud_divisor(CLK_HZ, 2'd1),
    baud_divisor(CLK_HZ, 2'd2), baud_divisor(CLK_HZ, 2'd3)
  };

  drv_state_t state, nxt, target, succ;
  logic [3:0] gap_cnt;
  logic [1:0] cfg_sync, cfg_latched;
  logic [1:0] warm;
  logic [7:0] dout;
  logic       launch;
  bus_t       bus;

  sync2 #(.WIDTH(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (br_cfg),
    .q   (cfg_sync)
  );

  // Driven straight from registered iocs/iorw, so an async reset releases the bus at once.
  assign databus = (iocs && !iorw) ? dout : 8'bz;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    launch = 1'b0;
    target = nxt;
    succ   = POLL_RX;
    // warm holds off the first divisor write until the synchronizer has filled.
    if (state == GAP && gap_cnt == 4'd0) begin
      launch = 1'b1;
    end else if (state == INIT_LOW && !iocs && warm[1]) begin
      launch = 1'b1;
      target = INIT_LOW;
    end
    case (state)
      INIT_LOW:  succ = INIT_HIGH;
      INIT_HIGH: succ = POLL_RX;
      POLL_RX: begin
        if (cfg_sync != cfg_latched)  succ = INIT_LOW;
        else if (databus[STAT_RDA])   succ = READ_RX;
        else                          succ = POLL_RX;
      end
      READ_RX:   succ = POLL_TX;
      POLL_TX:   succ = databus[STAT_TBR] ? WRITE_TX : POLL_TX;
      WRITE_TX:  succ = POLL_RX;
      default:   succ = INIT_LOW;
    endcase
    bus = bus_of(target);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= INIT_LOW;
      nxt         <= INIT_LOW;
      gap_cnt     <= 4'd0;
      cfg_latched <= 2'b00;
      warm        <= 2'b00;
      iocs        <= 1'b0;
      iorw        <= 1'b1;
      ioaddr      <= ADDR_STAT;
      dout        <= 8'h00;
      rx_byte     <= 8'h00;
      rx_valid    <= 1'b0;
    end else begin
      warm     <= {warm[0], 1'b1};
      rx_valid <= 1'b0;
      if (launch) begin
        state  <= target;
        iocs   <= 1'b1;
        iorw   <= bus.rd;
        ioaddr <= bus.addr;
        case (target)
          INIT_LOW: begin
            cfg_latched <= cfg_sync;
            dout        <= DIV_TABLE[cfg_sync][7:0];
          end
          INIT_HIGH: dout <= DIV_TABLE[cfg_latched][15:8];
          WRITE_TX:  dout <= rx_byte;
          default:   ;
        endcase
      end else if (iocs) begin
        state   <= GAP;
        nxt     <= succ;
        gap_cnt <= GAP_LOAD;
        iocs    <= 1'b0;
        iorw    <= 1'b1;
        if (state == READ_RX) begin
          rx_byte  <= databus;
          rx_valid <= 1'b1;
        end
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// Two drivers (POLL_GAP 1 and 3) against a behavioural SPART model; every bus
// access is checked against a transaction-level expectation of the echo protocol.
module tb_spart_driver;

  localparam logic [15:0] DIV_REF [4] = '{16'h28B0, 16'h1457, 16'h0A2B, 16'h0515};

  typedef enum {X_DBL, X_DBH, X_PRX, X_RD, X_PTX, X_WR} exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic       rst_l [2];
  logic [1:0] cfg_l [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int GAP = (g == 0) ? 1 : 3;

    logic       iocs, iorw, rx_valid;
    logic [1:0] ioaddr;
    logic [7:0] rx_byte;
    wire  [7:0] databus;

    // SPART-side model: rda after rx_wait status polls, tbr after tx_wait polls.
    logic       tx_phase = 1'b0;
    int         polls    = 0;
    int         rx_wait  = 5;
    int         tx_wait  = 3;
    logic [7:0] rx_data  = 8'hA5;
    logic       noisy    = 1'b0;
    logic [7:0] noise    = 8'h00;
    logic [7:0] stat, resp;

    // Driver-side expectation
    exp_t       want     = X_DBL;
    logic [1:0] cfg_prog = 2'b00;
    logic [15:0] dv      = 16'h0000;
    logic [7:0] echo     = 8'h00;
    logic       pulse_due = 1'b0;
    int         cyc      = 0;
    int         last_acc = -1;
    int         echo_cnt = 0;
    int         prog_cnt = 0;

    spart_driver #(.CLK_HZ(50_000_000), .POLL_GAP(GAP)) dut (
      .clk      (clk),
      .rst      (rst_l[g]),
      .br_cfg   (cfg_l[g]),
      .iocs     (iocs),
      .iorw     (iorw),
      .ioaddr   (ioaddr),
      .databus  (databus),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid)
    );

    always_comb begin
      stat = noisy ? noise : 8'h00;
      if (!tx_phase) stat[0] = (polls >= rx_wait);
      else           stat[1] = (polls >= tx_wait);
      resp = 8'h00;
      if (iocs && iorw) resp = (ioaddr == 2'b00) ? rx_data : stat;
    end

    assign databus = (iocs && !iorw) ? 8'bz : resp;

    always @(posedge clk) begin
      noise <= 8'($urandom);
      if (!rst_l[g]) begin
        tx_phase <= 1'b0;
        polls    <= 0;
      end else if (iocs) begin
        if (iorw && ioaddr == 2'b01) begin
          polls <= polls + 1;
        end else if (iorw && ioaddr == 2'b00) begin
          tx_phase <= 1'b1;
          polls    <= 0;
        end else if (!iorw && ioaddr == 2'b00) begin
          tx_phase <= 1'b0;
          polls    <= 0;
          noisy    <= 1'b1;
          rx_data  <= 8'($urandom);
          rx_wait  <= int'($urandom_range(0, 6));
          tx_wait  <= int'($urandom_range(0, 4));
        end
      end
    end

    task automatic acc(input string tag, input logic rd, input logic [1:0] a, input logic [7:0] d);
      check($sformatf("l%0d_%s_rw", g, tag), 32'(iorw), 32'(rd));
      check($sformatf("l%0d_%s_addr", g, tag), 32'(ioaddr), 32'(a));
      check($sformatf("l%0d_%s_bus", g, tag), 32'(databus), 32'(d));
    endtask

    always @(negedge clk) begin
      if (!rst_l[g]) begin
        check($sformatf("l%0d_rst_iocs", g), 32'(iocs), 32'd0);
        check($sformatf("l%0d_rst_iorw", g), 32'(iorw), 32'd1);
        check($sformatf("l%0d_rst_ioaddr", g), 32'(ioaddr), 32'd1);
        check($sformatf("l%0d_rst_rx_byte", g), 32'(rx_byte), 32'd0);
        check($sformatf("l%0d_rst_rx_valid", g), 32'(rx_valid), 32'd0);
        check($sformatf("l%0d_rst_bus", g), 32'(databus), 32'd0);
        want      = X_DBL;
        pulse_due = 1'b0;
        last_acc  = -1;
        cyc       = 0;
      end else begin
        cyc++;
        check($sformatf("l%0d_rx_valid", g), 32'(rx_valid), 32'(pulse_due));
        if (pulse_due) check($sformatf("l%0d_rx_byte", g), 32'(rx_byte), 32'(echo));
        pulse_due = 1'b0;
        if (!iocs) begin
          check($sformatf("l%0d_idle_bus", g), 32'(databus), 32'd0);
        end else begin
          if (last_acc >= 0) check($sformatf("l%0d_spacing", g), 32'(cyc - last_acc), 32'(GAP + 1));
          last_acc = cyc;
          case (want)
            X_DBL: begin
              cfg_prog = cfg_l[g];
              dv = DIV_REF[cfg_prog];
              acc("div_low", 1'b0, 2'b10, dv[7:0]);
              prog_cnt++;
              want = X_DBH;
            end
            X_DBH: begin
              acc("div_high", 1'b0, 2'b11, dv[15:8]);
              want = X_PRX;
            end
            X_PRX: begin
              acc("poll_rx", 1'b1, 2'b01, stat);
              if (cfg_l[g] != cfg_prog) want = X_DBL;
              else if (stat[0])         want = X_RD;
            end
            X_RD: begin
              acc("read_rx", 1'b1, 2'b00, rx_data);
              echo      = rx_data;
              pulse_due = 1'b1;
              want      = X_PTX;
            end
            X_PTX: begin
              acc("poll_tx", 1'b1, 2'b01, stat);
              if (stat[1]) want = X_WR;
            end
            default: begin
              acc("write_tx", 1'b0, 2'b00, echo);
              echo_cnt++;
              want = X_PRX;
            end
          endcase
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    int n0;
    int p0;
    rst_l[0] = 1'b0;
    rst_l[1] = 1'b0;
    cfg_l[0] = 2'b01;
    cfg_l[1] = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    rst_l[0] = 1'b1;
    rst_l[1] = 1'b1;

    // First echo (0xA5) with the fixed 5-poll / 3-poll status pattern.
    budget = 0;
    while (lane[0].echo_cnt < 1 && budget < 500) begin @(negedge clk); #1; budget++; end
    check("first_echo_wait", 32'(budget < 500), 32'd1);

    // Reconfigure 01 -> 11 while the byte is still in flight.
    budget = 0;
    while (lane[0].want != X_PTX && budget < 500) begin @(negedge clk); #1; budget++; end
    check("reach_poll_tx", 32'(budget < 500), 32'd1);
    n0 = lane[0].echo_cnt;
    p0 = lane[0].prog_cnt;
    cfg_l[0] = 2'b11;
    budget = 0;
    while (lane[0].prog_cnt == p0 && budget < 500) begin @(negedge clk); #1; budget++; end
    check("reprogram_wait", 32'(budget < 500), 32'd1);
    check("echo_before_reprogram", 32'(lane[0].echo_cnt), 32'(n0 + 1));

    budget = 0;
    while (lane[0].echo_cnt < n0 + 4 && budget < 2000) begin @(negedge clk); #1; budget++; end
    check("more_echoes_wait", 32'(budget < 2000), 32'd1);

    // Async reset in the middle of a WRITE_TX cycle.
    budget = 0;
    while (!(lane[0].iocs && !lane[0].iorw && lane[0].ioaddr == 2'b00) && budget < 1000) begin
      @(negedge clk); #1; budget++;
    end
    check("reach_write_tx", 32'(budget < 1000), 32'd1);
    rst_l[0] = 1'b0;
    #1;
    check("async_iocs", 32'(lane[0].iocs), 32'd0);
    check("async_bus", 32'(lane[0].databus), 32'd0);
    check("async_rx_byte", 32'(lane[0].rx_byte), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    p0 = lane[0].prog_cnt;
    n0 = lane[0].echo_cnt;
    rst_l[0] = 1'b1;
    budget = 0;
    while (lane[0].prog_cnt == p0 && budget < 100) begin @(negedge clk); #1; budget++; end
    check("reinit_after_rst", 32'(budget < 100), 32'd1);

    budget = 0;
    while ((lane[0].echo_cnt < n0 + 3 || lane[1].echo_cnt < 5) && budget < 5000) begin
      @(negedge clk); #1; budget++;
    end
    check("final_echo_wait", 32'(budget < 5000), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spart_driver.md
Name: spart_driver

Overview:
- Bus-master stand-in for the processor that sits directly upstream of the SPART control block on the iocs/iorw/ioaddr/databus interface.
- After reset it programs the 16-bit baud divisor from the board DIP switches (br_cfg).
- It then runs an echo loop: poll status, read the received byte, poll status, write the byte back for transmission.
- It is the top-level traffic generator for the board demo and the SPART bench.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz; divisor table derives from it.
- POLL_GAP, 1, idle cycles (iocs=0) inserted after every bus access; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low.
- br_cfg  in  2  DIP baud select, asynchronous to clk
- iocs  out  1  SPART chip select; one bus access per cycle it is high
- iorw  out  1  1=read, 0=write
- ioaddr  out  2  00 rx/tx buffer, 01 status, 10 divisor low, 11 divisor high
- databus  inout  8  driven by driver only when iocs=1 and iorw=0, else Z
- rx_byte  out  8  last byte read from the receive buffer (debug/LEDs)
- rx_valid  out  1  one-cycle pulse when rx_byte updates

Behaviour:
- Reset values:
  - iocs=0, iorw=1, ioaddr=01, databus=Z, rx_byte=0x00, rx_valid=0.
  - State=INIT_LOW; sync flops=00; cfg_latched=00; gap counter=0.
- br_cfg synchronisation:
  - Passes through a 2-flop synchronizer.
  - cfg_latched captures the synchronized value when entering INIT_LOW.
- Divisor = round(CLK_HZ/baud)-1, 16 bits. At 50 MHz:
  - 00: 4800 -> 0x28B0
  - 01: 9600 -> 0x1457
  - 10: 19200 -> 0x0A2B
  - 11: 38400 -> 0x0515
- Bus access timing:
  - Every access is exactly one cycle with iocs=1, followed by POLL_GAP cycles with iocs=0 (GAP state).
  - During GAP, iorw=1 and databus=Z.
  - Read data is sampled at the rising edge that ends the iocs=1 cycle.
- States; each bus state lasts 1 cycle, then goes to GAP, and GAP then goes to the listed successor:
  - INIT_LOW: write, ioaddr=10, databus=divisor[7:0] -> GAP -> INIT_HIGH.
  - INIT_HIGH: write, ioaddr=11, databus=divisor[15:8] -> GAP -> POLL_RX.
  - POLL_RX: read, ioaddr=01.
    - If synced br_cfg != cfg_latched -> GAP -> INIT_LOW (reconfigure; takes priority).
    - Else if status[0] (rda) -> GAP -> READ_RX.
    - Else -> GAP -> POLL_RX.
  - READ_RX: read, ioaddr=00; rx_byte<=databus and rx_valid=1 on that edge -> GAP -> POLL_TX.
  - POLL_TX: read, ioaddr=01.
    - If status[1] (tbr) -> GAP -> WRITE_TX.
    - Else -> GAP -> POLL_TX.
  - WRITE_TX: write, ioaddr=00, databus=rx_byte -> GAP -> POLL_RX.
- The GAP successor is held in a next-state register.
- Boundary conditions:
  - Config changes are checked only in POLL_RX, so a byte in flight is always echoed before reprogramming.
  - No timeout: polling continues indefinitely.
  - Status bits [7:2] are ignored.
  - rda and tbr seen in the same POLL_RX: only rda matters.
  - Async reset mid-operation: all outputs go to reset values immediately, databus goes Z in the same cycle, and the init sequence reruns.
  - A byte held in rx_byte is discarded on reset.
  - databus is never driven in any read or GAP cycle (no contention).

Decomposition:
- Package spart_pkg holds:
  - ioaddr constants ADDR_BUF=2'b00, ADDR_STAT=2'b01, ADDR_DBL=2'b10, ADDR_DBH=2'b11.
  - Status bit indices STAT_RDA=0, STAT_TBR=1.
  - Function baud_divisor(clk_hz, sel) returning 16 bits.
  - State enum drv_state_t.
- One sub-module: sync2, a 2-bit two-flop synchronizer for br_cfg, reusable elsewhere.

Test Plan:
- br_cfg=01, release rst:
  - First access is write ioaddr=10 data 0x57.
  - After the gap, write ioaddr=11 data 0x14.
  - Then repeated status reads at ioaddr=01, with iocs high 1 cycle in every 2.
- Bench status model returns 0x00 for 5 polls, then 0x01; buffer returns 0xA5:
  - Read at ioaddr=00, rx_byte=0xA5, rx_valid pulses once.
  - Status polls then continue at ioaddr=01.
- Status returns tbr=0 for 3 polls, then 0x02:
  - Exactly one write at ioaddr=00 data 0xA5.
  - databus is Z in all other cycles.
- Change br_cfg 01->11 while in POLL_TX:
  - Echo write completes first.
  - Next POLL_RX reconfigures: writes 0x15 to ioaddr=10, then 0x05 to ioaddr=11.
- Assert rst during the WRITE_TX cycle:
  - databus goes Z and iocs goes 0 asynchronously.
  - After release, divisor writes for the current br_cfg recur.
- POLL_GAP=3, br_cfg=00:
  - Writes 0xB0/0x28 to ioaddr 10/11.
  - Accesses are spaced exactly 4 cycles apart.
